// File: rtl/mem_process_pipeline_if.sv
// mem_process_pipeline_if: host load/dump bus and write-side outputs of the sample pipeline
//   en, load_we/load_addr/load_din, dump_addr : driven by master (host)
//   dump_dout, rd_addr, wr_valid/wr_addr/wr_data, count : driven by slave (pipeline)
interface mem_process_pipeline_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              en;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_din;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_dout;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [15:0]       count;
  modport master(
    output en, load_we, load_addr, load_din, dump_addr,
    input  dump_dout, rd_addr, wr_valid, wr_addr, wr_data, count
  );
  modport slave(
    input  en, load_we, load_addr, load_din, dump_addr,
    output dump_dout, rd_addr, wr_valid, wr_addr, wr_data, count
  );
endinterface

// File: rtl/mem_process_pipeline.sv
// mem_process_pipeline: streams source RAM through a saturating gain into destination RAM
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mem_process_pipeline_if (host load/dump, write-side status, counter)
module mem_process_pipeline #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int GAIN_SHIFT = 1
) (
  input logic clk,
  input logic rst,
  mem_process_pipeline_if.slave bus
);
  localparam int WW = DATA_W + GAIN_SHIFT;
  localparam logic signed [WW-1:0] MAXW = WW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [WW-1:0] MINW = -MAXW - 1;
  logic [DATA_W-1:0] src_mem [2**ADDR_W];
  logic [DATA_W-1:0] dst_mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q, src_q, wr_data_q, wr_data_d, dump_q;
  logic [ADDR_W-1:0] rd_addr_q, a1_q, a2_q, wr_addr_q;
  logic              v1_q, v2_q, wr_valid_q;
  logic [15:0]       count_q;
  logic signed [WW-1:0] w;
  always_comb begin
    w = {{GAIN_SHIFT{src_q[DATA_W-1]}}, src_q} <<< GAIN_SHIFT;
    wr_data_d = w > MAXW ? MAXW[DATA_W-1:0] : w < MINW ? MINW[DATA_W-1:0] : w[DATA_W-1:0];
  end
  // Arrays carry no reset; nonblocking read+write gives read-first on both RAMs.
  // ram_q is the array read, src_q the RAM output register.
  always_ff @(posedge clk) begin
    ram_q <= src_mem[rd_addr_q];
    if (bus.load_we) src_mem[bus.load_addr] <= bus.load_din;
    if (wr_valid_q && !rst) dst_mem[wr_addr_q] <= wr_data_q;
    dump_q <= rst ? '0 : dst_mem[bus.dump_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rd_addr_q  <= '0;
      v1_q       <= 1'b0;
      a1_q       <= '0;
      src_q      <= '0;
      v2_q       <= 1'b0;
      a2_q       <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      count_q    <= count_q + 16'd1;
      rd_addr_q  <= rd_addr_q + ADDR_W'(bus.en);
      v1_q       <= bus.en;
      a1_q       <= rd_addr_q;
      src_q      <= ram_q;
      v2_q       <= v1_q;
      a2_q       <= a1_q;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= v2_q;
      wr_addr_q  <= a2_q;
    end
  end
  assign bus.dump_dout = dump_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_mem_process_pipeline.sv
// tb_mem_process_pipeline: scoreboard bench for mem_process_pipeline
module tb_mem_process_pipeline;
  localparam int AW = 4;
  localparam int DW = 8;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_process_pipeline_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_process_pipeline #(.ADDR_W(AW), .DATA_W(DW), .GAIN_SHIFT(1)) dut(.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  wr_t sb[$];
  wr_t e;
  logic [DW-1:0] src_m [16];
  logic [DW-1:0] dst_m [16];
  bit known [16];
  logic [AW-1:0] a_m;
  logic [15:0] cnt_m;
  logic [15:0] c0;
  logic [DW-1:0] dump_exp;
  bit dump_ok = 0;
  bit started = 0;
  bit pat [7] = '{1, 0, 1, 1, 0, 0, 1};
  function automatic logic [DW-1:0] f(logic [DW-1:0] v);
    int x = int'($signed(v)) * 2;
    if (x > 127) x = 127;
    if (x < -128) x = -128;
    return DW'(x);
  endfunction
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // Reference model: issue order, source contents (read-first), counter.
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      a_m = '0;
      cnt_m = '0;
      sb.delete();
    end else begin
      cnt_m++;
      if (bus.en) begin
        sb.push_back('{a: a_m, d: f(src_m[a_m])});
        a_m++;
      end
    end
    if (bus.load_we) src_m[bus.load_addr] = bus.load_din;
  end
  // Monitor: pops one expected write per wr_valid, tracks destination contents for dump checks.
  always @(negedge clk) begin
    if (dump_ok) chk("dump_dout", int'(bus.dump_dout), int'(dump_exp));
    dump_ok = rst || known[bus.dump_addr];
    dump_exp = rst ? '0 : dst_m[bus.dump_addr];
    if (started) begin
      chk("count", int'(bus.count), int'(cnt_m));
      chk("rd_addr", int'(bus.rd_addr), int'(a_m));
      if (bus.wr_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required none", bus.wr_addr, bus.wr_data);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", int'(bus.wr_addr), int'(e.a));
          chk("wr_data", int'(bus.wr_data), int'(e.d));
          if (!rst) begin
            dst_m[e.a] = e.d;
            known[e.a] = 1;
          end
        end
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic load(int a, int d);
    bus.load_we = 1'b1;
    bus.load_addr = AW'(a);
    bus.load_din = DW'(d);
    tick();
    bus.load_we = 1'b0;
  endtask
  task automatic dump(int a, int exp);
    bus.dump_addr = AW'(a);
    tick();
    chk("dump", int'(bus.dump_dout), exp);
  endtask
  initial begin
    bus.en = 1'b0;
    bus.load_we = 1'b0;
    bus.load_addr = '0;
    bus.load_din = '0;
    bus.dump_addr = '0;
    tick(2);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_rd_addr", int'(bus.rd_addr), 0);
    chk("rst_wr_valid", int'(bus.wr_valid), 0);
    chk("rst_wr_data", int'(bus.wr_data), 0);
    chk("rst_dump", int'(bus.dump_dout), 0);
    rst = 1'b0;
    tick(5);
    chk("count5", int'(bus.count), 5);
    load(0, 'h10); load(1, 'h20); load(2, 'h30); load(3, 'h05);
    rst = 1'b1;
    bus.en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("lat_e1", int'(bus.wr_valid), 0);
    tick();
    chk("lat_e2", int'(bus.wr_valid), 0);
    tick();
    chk("lat_e3_valid", int'(bus.wr_valid), 1);
    chk("lat_e3_addr", int'(bus.wr_addr), 0);
    chk("lat_e3_data", int'(bus.wr_data), 'h20);
    tick();
    bus.en = 1'b0;
    tick(4);
    dump(0, 'h20); dump(1, 'h40); dump(2, 'h60); dump(3, 'h0A);
    load(4, 'h50); load(5, 'hB0); load(6, 'hF0); load(7, 'h7F);
    bus.en = 1'b1;
    tick(4);
    bus.en = 1'b0;
    tick(4);
    dump(4, 'h7F); dump(5, 'h80); dump(6, 'hE0); dump(7, 'h7F);
    load(8, 'h01); load(9, 'h02); load(10, 'h03); load(11, 'h04);
    foreach (pat[i]) begin
      bus.en = pat[i];
      tick();
    end
    bus.en = 1'b0;
    tick(4);
    chk("bubble_rd_addr", int'(bus.rd_addr), 12);
    dump(8, 'h02); dump(9, 'h04); dump(10, 'h06); dump(11, 'h08);
    load(12, 'h11);
    bus.en = 1'b1;
    bus.load_we = 1'b1;
    bus.load_addr = AW'(12);
    bus.load_din = 'h33;
    tick();
    bus.en = 1'b0;
    bus.load_we = 1'b0;
    tick(4);
    dump(12, 'h22);
    load(13, 'h40); load(14, 'hC0); load(15, 'h01);
    load(0, 'h31); load(1, 'h32); load(2, 'h33); load(3, 'h34);
    bus.dump_addr = '0;
    bus.en = 1'b1;
    tick(20);
    chk("wrap_rd_addr", int'(bus.rd_addr), 1);
    bus.en = 1'b0;
    tick(4);
    dump(0, 'h62); dump(1, 'h64); dump(13, 'h7F); dump(14, 'h80);
    bus.en = 1'b1;
    tick(20);
    rst = 1'b1;
    tick();
    chk("midrst_wr_valid", int'(bus.wr_valid), 0);
    chk("midrst_rd_addr", int'(bus.rd_addr), 0);
    rst = 1'b0;
    tick(2);
    chk("midrst_e2", int'(bus.wr_valid), 0);
    tick();
    chk("midrst_e3_valid", int'(bus.wr_valid), 1);
    chk("midrst_e3_addr", int'(bus.wr_addr), 0);
    bus.en = 1'b0;
    tick(4);
    dump(0, 'h62);
    c0 = cnt_m;
    tick(65536);
    chk("count_wrap", int'(bus.count), int'(c0));
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
